// File: rtl/regbank_pkg.sv
// Shared constants and sizing helpers for the multi-port register bank.
// Provides byte-lane count, minimum-1 address width and counter ceiling.
package regbank_pkg;

    localparam logic [15:0] COLL_MAX = 16'hFFFF;

    function automatic int lanes(input int width);
        return width / 8;
    endfunction

    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regbank_lane_arb.sv
// Per-word, per-byte-lane priority select across the write ports.
// Ports: hit (requesting ports), data (bytes) -> sel, we, lose mask.
module regbank_lane_arb #(
    parameter int NWR = 2
) (
    input  logic [NWR-1:0]   hit,
    input  logic [NWR*8-1:0] data,
    output logic [7:0]       sel,
    output logic             we,
    output logic [NWR-1:0]   lose
);

    // Lowest-index requester wins; every later requester is a loser.
    always_comb begin
        sel  = 8'h00;
        we   = 1'b0;
        lose = '0;
        for (int i = 0; i < NWR; i++) begin
            if (hit[i]) begin
                if (we) begin
                    lose[i] = 1'b1;
                end else begin
                    we  = 1'b1;
                    sel = data[i*8 +: 8];
                end
            end
        end
    end

endmodule

// File: rtl/regbank_nwp.sv
// DEPTH-word register bank with NWR prioritised byte-enabled write ports,
// NRD combinational read ports (optional bypass) and collision reporting.
// Ports: clk, reset, wen/waddr/wdata/wbe, raddr/rdata, coll/coll_port/coll_cnt.
module regbank_nwp #(
    parameter int WIDTH  = 32,
    parameter int DEPTH  = 16,
    parameter int NWR    = 2,
    parameter int NRD    = 2,
    parameter int BYPASS = 1,
    parameter int AW     = regbank_pkg::addr_w(DEPTH)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NWR-1:0]                wen,
    input  logic [NWR*AW-1:0]             waddr,
    input  logic [NWR*WIDTH-1:0]          wdata,
    input  logic [NWR*(WIDTH/8)-1:0]      wbe,
    input  logic [NRD*AW-1:0]             raddr,
    output logic [NRD*WIDTH-1:0]          rdata,
    output logic                          coll,
    output logic [NWR-1:0]                coll_port,
    output logic [15:0]                   coll_cnt
);

    import regbank_pkg::*;

    localparam int NB = lanes(WIDTH);

    if (WIDTH % 8 != 0 || NWR < 1 || NRD < 1) begin : g_bad_cfg
        $fatal(1, "regbank_nwp: invalid WIDTH/NWR/NRD");
    end

    logic [WIDTH-1:0]          mem [DEPTH];
    logic [DEPTH*WIDTH-1:0]    nxt;
    logic [DEPTH*NB*NWR-1:0]   lose_flat;
    logic [NWR-1:0]            lose_all;

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        for (genvar b = 0; b < NB; b++) begin : g_lane
            logic [NWR-1:0]   hit;
            logic [NWR*8-1:0] bytes;
            logic [7:0]       sel;
            logic             we;

            // Out-of-range addresses never match any word, so they
            // neither write nor take part in collisions.
            for (genvar i = 0; i < NWR; i++) begin : g_port
                assign hit[i] = wen[i] && wbe[i*NB+b] &&
                                (waddr[i*AW +: AW] == AW'(w));
                assign bytes[i*8 +: 8] = wdata[i*WIDTH + b*8 +: 8];
            end

            regbank_lane_arb #(.NWR(NWR)) u_arb (
                .hit  (hit),
                .data (bytes),
                .sel  (sel),
                .we   (we),
                .lose (lose_flat[(w*NB+b)*NWR +: NWR])
            );

            assign nxt[w*WIDTH + b*8 +: 8] =
                we ? sel : mem[w][b*8 +: 8];
        end
    end

    always_comb begin
        lose_all = '0;
        for (int k = 0; k < DEPTH*NB; k++) begin
            lose_all = lose_all | lose_flat[k*NWR +: NWR];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= '0;
            end
        end else begin
            for (int w = 0; w < DEPTH; w++) begin
                mem[w] <= nxt[w*WIDTH +: WIDTH];
            end
        end
    end

    // Reads are forced to 0 during reset so a pending bypassed
    // write cannot leak through while storage is being cleared.
    always_comb begin
        rdata = '0;
        for (int j = 0; j < NRD; j++) begin
            logic [AW-1:0] ra;
            ra = raddr[j*AW +: AW];
            if (!reset && 32'(ra) < DEPTH) begin
                if (BYPASS != 0) begin
                    rdata[j*WIDTH +: WIDTH] = nxt[32'(ra)*WIDTH +: WIDTH];
                end else begin
                    rdata[j*WIDTH +: WIDTH] = mem[ra];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            coll      <= 1'b0;
            coll_port <= '0;
            coll_cnt  <= '0;
        end else begin
            coll      <= |lose_all;
            coll_port <= lose_all;
            if (|lose_all && coll_cnt != COLL_MAX) begin
                coll_cnt <= coll_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_regbank_nwp.sv
// Directed self-checking bench: DUT a (DEPTH 16, bypass) and
// DUT b (DEPTH 12, no bypass) share the same write/read stimulus.
module tb_regbank_nwp;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  wen;
    logic [7:0]  waddr;
    logic [63:0] wdata;
    logic [7:0]  wbe;
    logic [7:0]  raddr;
    logic [63:0] rdata_a, rdata_b;
    logic        coll_a, coll_b;
    logic [1:0]  cport_a, cport_b;
    logic [15:0] cnt_a, cnt_b;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    regbank_nwp #(.WIDTH(32), .DEPTH(16), .NWR(2), .NRD(2), .BYPASS(1)) u_a (
        .clk(clk), .reset(reset), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .raddr(raddr), .rdata(rdata_a),
        .coll(coll_a), .coll_port(cport_a), .coll_cnt(cnt_a)
    );

    regbank_nwp #(.WIDTH(32), .DEPTH(12), .NWR(2), .NRD(2), .BYPASS(0)) u_b (
        .clk(clk), .reset(reset), .wen(wen), .waddr(waddr),
        .wdata(wdata), .wbe(wbe), .raddr(raddr), .rdata(rdata_b),
        .coll(coll_b), .coll_port(cport_b), .coll_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int p, input logic [3:0] a,
                      input logic [31:0] d, input logic [3:0] be);
        wen[p]          = 1'b1;
        waddr[p*4 +: 4] = a;
        wdata[p*32 +: 32] = d;
        wbe[p*4 +: 4]   = be;
    endtask

    task automatic idle();
        wen   = '0;
        waddr = '0;
        wdata = '0;
        wbe   = '0;
    endtask

    task automatic rd(input logic [3:0] a0, input logic [3:0] a1);
        raddr = {a1, a0};
    endtask

    initial begin
        reset = 1'b1;
        idle();
        rd(4'd0, 4'd1);
        tick();
        chk("rst_rd0_a", rdata_a[31:0], 32'h0);
        chk("rst_cnt_a", {16'h0, cnt_a}, 32'h0);
        chk("rst_coll_b", {31'h0, coll_b}, 32'h0);
        reset = 1'b0;

        // plain writes, two ports, different words
        wr(0, 4'd1, 32'hDEADBEEF, 4'hF);
        wr(1, 4'd2, 32'h01020304, 4'hF);
        tick();
        idle();
        rd(4'd1, 4'd2);
        #1;
        chk("load_w1_a", rdata_a[31:0], 32'hDEADBEEF);
        chk("load_w2_b", rdata_b[63:32], 32'h01020304);
        chk("load_coll_a", {31'h0, coll_a}, 32'h0);

        // priority collision on word 3
        wr(0, 4'd3, 32'h11111111, 4'hF);
        wr(1, 4'd3, 32'h22222222, 4'hF);
        tick();
        idle();
        rd(4'd3, 4'd1);
        #1;
        chk("prio_w3_a", rdata_a[31:0], 32'h11111111);
        chk("prio_w3_b", rdata_b[31:0], 32'h11111111);
        chk("prio_coll_a", {31'h0, coll_a}, 32'h1);
        chk("prio_cport_a", {30'h0, cport_a}, 32'h2);
        chk("prio_cnt_a", {16'h0, cnt_a}, 32'h1);
        tick();
        chk("prio_pulse_a", {31'h0, coll_a}, 32'h0);
        chk("prio_cnt_hold", {16'h0, cnt_a}, 32'h1);

        // disjoint byte merge on word 5
        wr(0, 4'd5, 32'hAABBCCDD, 4'hF);
        tick();
        wr(0, 4'd5, 32'h00001234, 4'b0011);
        wr(1, 4'd5, 32'h56780000, 4'b1100);
        tick();
        idle();
        rd(4'd5, 4'd5);
        #1;
        chk("merge_w5_a", rdata_a[31:0], 32'h56781234);
        chk("merge_w5_b", rdata_b[63:32], 32'h56781234);
        chk("merge_coll_a", {31'h0, coll_a}, 32'h0);
        chk("merge_cnt_a", {16'h0, cnt_a}, 32'h1);

        // bypass vs stored read of word 7
        rd(4'd7, 4'd7);
        wr(0, 4'd7, 32'hCAFEF00D, 4'hF);
        #1;
        chk("byp_on_a", rdata_a[31:0], 32'hCAFEF00D);
        chk("byp_off_b", rdata_b[31:0], 32'h0);
        tick();
        idle();
        #1;
        chk("byp_after_b", rdata_b[31:0], 32'hCAFEF00D);

        // address 13: out of range for b, in range for a
        wr(0, 4'd13, 32'h12345678, 4'hF);
        wr(1, 4'd13, 32'h9ABCDEF0, 4'hF);
        rd(4'd13, 4'd1);
        tick();
        idle();
        #1;
        chk("oob_rd_b", rdata_b[31:0], 32'h0);
        chk("oob_w1_b", rdata_b[63:32], 32'hDEADBEEF);
        chk("oob_coll_b", {31'h0, coll_b}, 32'h0);
        chk("oob_cnt_b", {16'h0, cnt_b}, 32'h1);
        chk("inr_rd_a", rdata_a[31:0], 32'h12345678);
        chk("inr_coll_a", {31'h0, coll_a}, 32'h1);
        chk("inr_cnt_a", {16'h0, cnt_a}, 32'h2);

        // zero byte-enable is a no-op, no collision
        wr(0, 4'd1, 32'hFFFFFFFF, 4'h0);
        wr(1, 4'd1, 32'h00000055, 4'hF);
        rd(4'd1, 4'd3);
        tick();
        idle();
        #1;
        chk("wbe0_w1_a", rdata_a[31:0], 32'h00000055);
        chk("wbe0_coll_a", {31'h0, coll_a}, 32'h0);

        // reset mid-write, between edges
        wr(0, 4'd1, 32'h77777777, 4'hF);
        #2;
        reset = 1'b1;
        #1;
        chk("mrst_rd_a", rdata_a[31:0], 32'h0);
        chk("mrst_w3_b", rdata_b[63:32], 32'h0);
        chk("mrst_cnt_a", {16'h0, cnt_a}, 32'h0);
        tick();
        idle();
        reset = 1'b0;
        tick();
        chk("post_rst_w1_a", rdata_a[31:0], 32'h0);
        chk("post_rst_w3_a", rdata_a[63:32], 32'h0);

        // saturation: 65537 consecutive collision cycles on word 0
        wr(0, 4'd0, 32'hA5A5A5A5, 4'hF);
        wr(1, 4'd0, 32'h5A5A5A5A, 4'hF);
        repeat (65534) tick();
        chk("sat_fffe_a", {16'h0, cnt_a}, 32'h0000FFFE);
        tick();
        chk("sat_ffff_a", {16'h0, cnt_a}, 32'h0000FFFF);
        tick();
        tick();
        chk("sat_hold_a", {16'h0, cnt_a}, 32'h0000FFFF);
        chk("sat_hold_b", {16'h0, cnt_b}, 32'h0000FFFF);
        chk("sat_coll_a", {31'h0, coll_a}, 32'h1);
        chk("sat_cport_a", {30'h0, cport_a}, 32'h2);
        idle();
        tick();
        chk("sat_end_coll", {31'h0, coll_a}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
